// File: rtl/dcache_2way_controller_pkg.sv
// Shared definitions for the 2-way L1 data cache controller: geometry, tag-entry
// and address field positions, FSM encodings and the line word-merge helper.
package dcache_2way_controller_pkg;

  localparam int IDX_W  = 4;
  localparam int OFS_W  = 5;
  localparam int TAG_W  = 23;
  localparam int LINE_W = 256;
  localparam int TENT_W = TAG_W + 2;

  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;
  localparam int TAG_MSB   = 22;

  localparam int ADDR_TAG_LSB  = 9;
  localparam int ADDR_IDX_LSB  = 5;
  localparam int ADDR_WORD_LSB = 2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;
  localparam logic [1:0] ST_REFILL    = 2'd3;

  typedef struct packed {
    logic hit0;
    logic hit1;
    logic victim_way;
    logic victim_dirty;
  } vsel_t;

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [2:0]        word,
                                                   input logic [31:0]       data);
    logic [LINE_W-1:0] r;
    r = line;
    r[{word, 5'b0} +: 32] = data;
    return r;
  endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Combinational hit detection on both ways and victim choice
// (invalid way first, otherwise the way the LRU bit points at).
module dcache_victim_sel
  import dcache_2way_controller_pkg::*;
(
  input  logic [TENT_W-1:0] tag0,
  input  logic [TENT_W-1:0] tag1,
  input  logic [TAG_W-1:0]  addr_tag,
  input  logic              lru,
  output vsel_t             sel
);

  always_comb begin
    sel.hit0 = tag0[VALID_BIT] && (tag0[TAG_MSB:0] == addr_tag);
    sel.hit1 = tag1[VALID_BIT] && (tag1[TAG_MSB:0] == addr_tag);
    if (!tag0[VALID_BIT])      sel.victim_way = 1'b0;
    else if (!tag1[VALID_BIT]) sel.victim_way = 1'b1;
    else                       sel.victim_way = lru;
    sel.victim_dirty = sel.victim_way ? (tag1[VALID_BIT] & tag1[DIRTY_BIT])
                                      : (tag0[VALID_BIT] & tag0[DIRTY_BIT]);
  end

endmodule

// File: rtl/dcache_2way_controller.sv
// Miss/refill sequencer for the 2-way set-associative L1 data cache.
// Define DCACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module dcache_2way_controller
  import dcache_2way_controller_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [IDX_W-1:0]  sram_idx_o,
  output logic              sram_we_o,
  output logic              sram_way_o,
  output logic [TENT_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  input  logic [TENT_W-1:0] sram_tag0_i,
  input  logic [TENT_W-1:0] sram_tag1_i,
  input  logic [LINE_W-1:0] sram_data0_i,
  input  logic [LINE_W-1:0] sram_data1_i,
  output logic              mem_req_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  logic [1:0]        state, state_nx;
  logic [15:0]       lru;
  logic              victim_r;
  logic [LINE_W-1:0] fill_r;
  logic [TAG_W-1:0]  atag;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        word;
  vsel_t             sel;
  logic              hit;
  logic [LINE_W-1:0] hit_line, victim_line;
  logic [TENT_W-1:0] victim_tent;
  logic              unused_addr_lsb;

  assign atag            = cpu_addr_i[31:ADDR_TAG_LSB];
  assign idx             = cpu_addr_i[ADDR_TAG_LSB-1:ADDR_IDX_LSB];
  assign word            = cpu_addr_i[ADDR_IDX_LSB-1:ADDR_WORD_LSB];
  assign unused_addr_lsb = ^cpu_addr_i[ADDR_WORD_LSB-1:0];
  assign sram_idx_o      = idx;

  dcache_victim_sel u_victim_sel (
    .tag0     (sram_tag0_i),
    .tag1     (sram_tag1_i),
    .addr_tag (atag),
    .lru      (lru[idx]),
    .sel      (sel)
  );

  assign hit         = sel.hit0 | sel.hit1;
  assign hit_line    = sel.hit0 ? sram_data0_i : sram_data1_i;
  assign victim_line = victim_r ? sram_data1_i : sram_data0_i;
  assign victim_tent = victim_r ? sram_tag1_i : sram_tag0_i;
  assign cpu_stall_o = (state != ST_IDLE) || (cpu_req_i && !hit);

  always_comb begin
    cpu_data_o  = '0;
    sram_we_o   = 1'b0;
    sram_way_o  = 1'b0;
    sram_tag_o  = '0;
    sram_data_o = '0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    state_nx    = state;
    case (state)
      ST_IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            cpu_data_o = hit_line[{word, 5'b0} +: 32];
            if (cpu_write_i) begin
              sram_we_o   = 1'b1;
              sram_way_o  = !sel.hit0;
              sram_tag_o  = {1'b1, 1'b1, atag};
              sram_data_o = merge_word(hit_line, word, cpu_data_i);
            end
          end else begin
            state_nx = sel.victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {victim_tent[TAG_MSB:0], idx, OFS_W'(0)};
        mem_data_o  = victim_line;
        if (mem_ack_i) state_nx = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {atag, idx, OFS_W'(0)};
        if (mem_ack_i) state_nx = ST_REFILL;
      end
      default: begin
        sram_we_o   = 1'b1;
        sram_way_o  = victim_r;
        sram_tag_o  = {1'b1, cpu_write_i, atag};
        sram_data_o = cpu_write_i ? merge_word(fill_r, word, cpu_data_i) : fill_r;
        state_nx    = ST_IDLE;
      end
    endcase
    // A refill or store hit that coincides with reset must not reach the arrays
    if (rst_i) sram_we_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      lru      <= '0;
      victim_r <= 1'b0;
      fill_r   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && cpu_req_i) begin
        if (hit) lru[idx] <= sel.hit0;
        else     victim_r <= sel.victim_way;
      end
      if (state == ST_ALLOCATE && mem_ack_i) fill_r <= mem_data_i;
      if (state == ST_REFILL) lru[idx] <= !victim_r;
    end
  end

`ifdef DCACHE_STATS_EN
  logic replay_r;

  // The hit that follows a refill is the replay of the miss, not a new hit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      replay_r   <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      replay_r <= (state == ST_REFILL);
      if (state == ST_IDLE && cpu_req_i) begin
        if (hit) begin
          if (!replay_r && hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
        end else if (miss_cnt_o != 32'hFFFF_FFFF) begin
          miss_cnt_o <= miss_cnt_o + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_2way_controller.sv
// Directed bench for dcache_2way_controller with a behavioural tag/data SRAM
// and a fixed-latency memory responder.
module tb_dcache_2way_controller;
  import dcache_2way_controller_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cpu_req_i, cpu_write_i;
  logic [31:0]       cpu_addr_i, cpu_data_i, cpu_data_o;
  logic              cpu_stall_o;
  logic [IDX_W-1:0]  sram_idx_o;
  logic              sram_we_o, sram_way_o;
  logic [TENT_W-1:0] sram_tag_o, sram_tag0_i, sram_tag1_i;
  logic [LINE_W-1:0] sram_data_o, sram_data0_i, sram_data1_i;
  logic              mem_req_o, mem_write_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_data_o, mem_data_i;
  logic              mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]       hit_cnt_o, miss_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  dcache_2way_controller dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_write_i  (cpu_write_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .sram_idx_o   (sram_idx_o),
    .sram_we_o    (sram_we_o),
    .sram_way_o   (sram_way_o),
    .sram_tag_o   (sram_tag_o),
    .sram_data_o  (sram_data_o),
    .sram_tag0_i  (sram_tag0_i),
    .sram_tag1_i  (sram_tag1_i),
    .sram_data0_i (sram_data0_i),
    .sram_data1_i (sram_data1_i),
    .mem_req_o    (mem_req_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] fill_line(input logic [31:0] addr);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = 32'h1000_0000 | ({addr[31:5], 5'b0} + 32'(i * 4));
    return l;
  endfunction

  // Behavioural SRAM: combinational read, write on the clock edge
  logic [TENT_W-1:0] tag_mem [2][16];
  logic [LINE_W-1:0] dat_mem [2][16];
  logic              mem_clr;
  int                we_count;
  logic              last_way;
  logic [TENT_W-1:0] last_tag;
  logic [LINE_W-1:0] last_data;

  assign sram_tag0_i  = tag_mem[0][sram_idx_o];
  assign sram_tag1_i  = tag_mem[1][sram_idx_o];
  assign sram_data0_i = dat_mem[0][sram_idx_o];
  assign sram_data1_i = dat_mem[1][sram_idx_o];

  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 16; s++) begin
          tag_mem[w][s] <= '0;
          dat_mem[w][s] <= '0;
        end
      we_count  <= 0;
      last_way  <= 1'b0;
      last_tag  <= '0;
      last_data <= '0;
    end else if (sram_we_o) begin
      tag_mem[sram_way_o][sram_idx_o] <= sram_tag_o;
      dat_mem[sram_way_o][sram_idx_o] <= sram_data_o;
      we_count  <= we_count + 1;
      last_way  <= sram_way_o;
      last_tag  <= sram_tag_o;
      last_data <= sram_data_o;
    end
  end

  // Memory responder: ack in the lat-th cycle of a request, log each completed transfer
  int                lat = 3;
  int                nlog = 0;
  logic [31:0]       log_addr [16];
  logic              log_wr   [16];
  logic [LINE_W-1:0] log_data [16];

  initial begin
    int cnt;
    cnt        = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        cnt++;
        if (cnt >= lat) begin
          mem_ack_i  = 1'b1;
          mem_data_i = fill_line(mem_addr_o);
          if (nlog < 16) begin
            log_addr[nlog] = mem_addr_o;
            log_wr[nlog]   = mem_write_o;
            log_data[nlog] = mem_data_o;
          end
          nlog++;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Starts at a negedge; returns stall cycle count and the load data of the replay hit
  task automatic do_miss(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         output int cycles, output logic [31:0] rdata);
    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_data_i  = wdata;
    cycles      = 0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (!cpu_stall_o) break;
      cycles++;
      @(negedge clk_i);
    end
    if (cycles >= 60) chk("miss_timeout", 1'b1, 1'b0);
    rdata = cpu_data_o;
    @(negedge clk_i);
    cpu_req_i   = 1'b0;
    cpu_write_i = 1'b0;
  endtask

  initial begin
    int          cyc, n0, w0;
    logic [31:0] rd;
    rst_i       = 1'b1;
    mem_clr     = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_write_i = 1'b0;
    cpu_addr_i  = '0;
    cpu_data_i  = '0;
    repeat (2) @(negedge clk_i);
    mem_clr = 1'b0;
    #1;
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_sram_we", sram_we_o, 1'b0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Cold miss, both ways invalid
    n0 = nlog; w0 = we_count;
    do_miss(32'h40, 1'b0, 32'h0, cyc, rd);
    chk("miss1_stall", cyc, 5);
    chk("miss1_ntrans", nlog - n0, 1);
    chk("miss1_alloc_addr", log_addr[n0], 32'h40);
    chk("miss1_alloc_wr", log_wr[n0], 1'b0);
    chk("miss1_writes", we_count - w0, 1);
    chk("miss1_way", last_way, 1'b0);
    chk("miss1_tag", last_tag, 25'h100_0000);
    chk("miss1_line", last_data, fill_line(32'h40));
    chk("miss1_rdata", rd, 32'h1000_0040);

    // Load hit
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h40;
    #1;
    chk("hit_ld_stall", cpu_stall_o, 1'b0);
    chk("hit_ld_data", cpu_data_o, 32'h1000_0040);
    chk("hit_ld_we", sram_we_o, 1'b0);
    @(negedge clk_i);

    // Store hit to word 1
    cpu_write_i = 1'b1; cpu_addr_i = 32'h44; cpu_data_i = 32'hDEAD_BEEF;
    #1;
    chk("hit_st_stall", cpu_stall_o, 1'b0);
    chk("hit_st_we", sram_we_o, 1'b1);
    chk("hit_st_way", sram_way_o, 1'b0);
    chk("hit_st_tag", sram_tag_o, 25'h180_0000);
    chk("hit_st_word1", sram_data_o[63:32], 32'hDEAD_BEEF);
    chk("hit_st_word0", sram_data_o[31:0], 32'h1000_0040);
    @(negedge clk_i);
    cpu_req_i = 1'b0; cpu_write_i = 1'b0;
    @(negedge clk_i);

    // Same set, way1 still invalid
    n0 = nlog;
    do_miss(32'h240, 1'b0, 32'h0, cyc, rd);
    chk("miss2_stall", cyc, 5);
    chk("miss2_alloc_addr", log_addr[n0], 32'h240);
    chk("miss2_way", last_way, 1'b1);
    chk("miss2_tag", last_tag, 25'h100_0001);
    chk("miss2_rdata", rd, 32'h1000_0240);

    // Same set, both valid: evict dirty way0 (LRU)
    n0 = nlog;
    do_miss(32'h440, 1'b0, 32'h0, cyc, rd);
    chk("miss3_stall", cyc, 8);
    chk("miss3_ntrans", nlog - n0, 2);
    chk("miss3_wb_addr", log_addr[n0], 32'h40);
    chk("miss3_wb_wr", log_wr[n0], 1'b1);
    chk("miss3_wb_word1", log_data[n0][63:32], 32'hDEAD_BEEF);
    chk("miss3_wb_word0", log_data[n0][31:0], 32'h1000_0040);
    chk("miss3_alloc_addr", log_addr[n0+1], 32'h440);
    chk("miss3_alloc_wr", log_wr[n0+1], 1'b0);
    chk("miss3_way", last_way, 1'b0);
    chk("miss3_tag", last_tag, 25'h100_0002);
    chk("miss3_rdata", rd, 32'h1000_0440);
`ifdef DCACHE_STATS_EN
    chk("stats_hits", hit_cnt_o, 32'd2);
    chk("stats_misses", miss_cnt_o, 32'd3);
`endif

    // Reset during ALLOCATE with the ack landing in the reset cycle
    n0 = nlog; w0 = we_count;
    lat = 2;
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h640;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    chk("rstmid_mem_req", mem_req_o, 1'b0);
    chk("rstmid_no_write", we_count - w0, 0);
    chk("rstmid_ack_seen", nlog - n0, 1);
    chk("rstmid_stall", cpu_stall_o, 1'b1);
`ifdef DCACHE_STATS_EN
    chk("rstmid_hits_clr", hit_cnt_o, 32'd0);
    chk("rstmid_misses_clr", miss_cnt_o, 32'd0);
`endif
    rst_i = 1'b0;
    lat   = 3;
    // LRU cleared, so both-valid set 2 now picks way0
    do_miss(32'h640, 1'b0, 32'h0, cyc, rd);
    chk("after_rst_stall", cyc, 5);
    chk("after_rst_writes", we_count - w0, 1);
    chk("after_rst_way", last_way, 1'b0);
    chk("after_rst_rdata", rd, 32'h1000_0640);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
